axis_bayer_subsampler: RTL and testbench

// Runtime-configurable Bayer-plane subsampler on an AXI4-Stream video path (tuser = SOF, tlast = EOL).
// Per frame it passes video through, extracts one 2x2 Bayer phase, or bins each 2x2 quad into one rounded average.

---
 rtl/axis_bayer_subsampler.sv | 190 +++++++++++++++++++
 tb/tb_axis_bayer_subsampler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_bayer_subsampler.sv
// axis_bayer_subsampler
// AXI4-Stream Bayer-plane subsampler: bypass, single 2x2 phase extraction,
// or 2x2 binning with rounding. Configuration is latched per frame on the
// SOF beat. The output stage is a single register with skid-free ready.
// C_MAX_WIDTH must be even and at least 4.
module axis_bayer_subsampler #(
   parameter int C_PIXEL_WIDTH = 8,
   parameter int C_MAX_WIDTH   = 4096
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [1:0]               cfg_mode,
   input  logic                     cfg_col_odd,
   input  logic                     cfg_row_odd,
   input  logic                     s_axis_tvalid,
   input  logic [C_PIXEL_WIDTH-1:0] s_axis_tdata,
   input  logic                     s_axis_tuser,
   input  logic                     s_axis_tlast,
   output logic                     s_axis_tready,
   output logic                     m_axis_tvalid,
   output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
   output logic                     m_axis_tuser,
   output logic                     m_axis_tlast,
   input  logic                     m_axis_tready,
   output logic                     status_err
);

   localparam int W    = C_PIXEL_WIDTH;
   localparam int HALF = C_MAX_WIDTH / 2;
   localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;

   localparam logic [1:0] MODE_BYPASS = 2'd0;
   localparam logic [1:0] MODE_PHASE  = 2'd1;
   localparam logic [1:0] MODE_BIN    = 2'd2;

   // latched per-frame configuration
   logic [1:0]    mode_l;
   logic          col_odd_l;
   logic          row_odd_l;

   // position within the frame
   logic          col_lsb;
   logic          row_lsb;
   logic [AW-1:0] idx;
   logic          over;

   logic          pend;
   logic [W-1:0]  p0;
   logic [W:0]    rd;
   logic [W:0]    mem [0:HALF-1];

   // per-beat effective values (SOF beat overrides latched state)
   logic          snext;
   logic [1:0]    mode_e;
   logic          codd_e;
   logic          rodd_e;
   logic          col_e;
   logic          row_e;
   logic [AW-1:0] idx_e;
   logic          over_e;
   logic [W:0]    hsum;
   logic [W-1:0]  avg;
   logic          emit;
   logic [W-1:0]  odata;
   logic          wr_en;
   logic          rd_en;
   logic          err_set;

   assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
   assign snext         = s_axis_tvalid && s_axis_tready;

   // resolve this beat's mode/position and what it produces
   always_comb begin
      mode_e  = mode_l;
      codd_e  = col_odd_l;
      rodd_e  = row_odd_l;
      col_e   = col_lsb;
      row_e   = row_lsb;
      idx_e   = idx;
      over_e  = over;
      if (s_axis_tuser) begin
         mode_e = (cfg_mode == 2'd3) ? MODE_BYPASS : cfg_mode;
         codd_e = cfg_col_odd;
         rodd_e = cfg_row_odd;
         col_e  = 1'b0;
         row_e  = 1'b0;
         idx_e  = '0;
         over_e = 1'b0;
      end
      hsum  = {1'b0, p0} + {1'b0, s_axis_tdata};
      avg   = W'(({1'b0, rd} + {1'b0, hsum} + (W+2)'(2)) >> 2);
      emit  = 1'b0;
      odata = s_axis_tdata;
      case (mode_e)
         MODE_PHASE: begin
            emit  = col_e && (row_e == rodd_e);
            odata = codd_e ? s_axis_tdata : p0;
         end
         MODE_BIN: begin
            emit  = col_e && row_e;
            odata = avg;
         end
         default: begin
            emit  = 1'b1;
            odata = s_axis_tdata;
         end
      endcase
      wr_en   = snext && (mode_e == MODE_BIN) && col_e && !row_e;
      rd_en   = snext && !col_e;
      err_set = snext && (((mode_e != MODE_BYPASS) && s_axis_tlast && !col_e) ||
                          ((mode_e == MODE_BIN) && over_e));
   end

   // configuration latch on the SOF beat
   always_ff @(posedge clk) begin
      if (reset) begin
         mode_l    <= MODE_BYPASS;
         col_odd_l <= 1'b0;
         row_odd_l <= 1'b0;
      end else if (snext && s_axis_tuser) begin
         mode_l    <= mode_e;
         col_odd_l <= codd_e;
         row_odd_l <= rodd_e;
      end
   end

   // column/row tracking; pair index wraps at HALF and flags the overflow
   always_ff @(posedge clk) begin
      if (reset) begin
         col_lsb <= 1'b0;
         row_lsb <= 1'b0;
         idx     <= '0;
         over    <= 1'b0;
         p0      <= '0;
      end else if (snext) begin
         if (!col_e)
            p0 <= s_axis_tdata;
         if (s_axis_tlast) begin
            col_lsb <= 1'b0;
            idx     <= '0;
            over    <= 1'b0;
            row_lsb <= !row_e;
         end else begin
            col_lsb <= !col_e;
            row_lsb <= row_e;
            if (col_e && (idx_e == AW'(HALF - 1))) begin
               idx  <= '0;
               over <= 1'b1;
            end else begin
               idx  <= col_e ? idx_e + AW'(1) : idx_e;
               over <= over_e;
            end
         end
      end
   end

   // half-sum line buffer; read issued on the even beat and held across stalls
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[idx_e] <= hsum;
      if (rd_en)
         rd <= mem[idx_e];
   end

   // output register, pending SOF flag and sticky error
   always_ff @(posedge clk) begin
      if (reset) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tuser  <= 1'b0;
         m_axis_tlast  <= 1'b0;
         pend          <= 1'b0;
         status_err    <= 1'b0;
      end else begin
         if (snext && emit) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= odata;
            m_axis_tuser  <= pend || s_axis_tuser;
            m_axis_tlast  <= s_axis_tlast;
         end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end
         if (snext)
            pend <= (pend || s_axis_tuser) && !emit;
         if (err_set)
            status_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_axis_bayer_subsampler.sv
// tb_axis_bayer_subsampler
// Scoreboard bench: the driver feeds a frame-level reference model on every
// accepted beat; a monitor pops expected pixels as the DUT hands them over.
module tb_axis_bayer_subsampler;

   localparam int W    = 8;
   localparam int CMAX = 16;
   localparam int HALF = CMAX / 2;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [1:0]   cfg_mode = '0;
   logic         cfg_col_odd = 1'b0;
   logic         cfg_row_odd = 1'b0;
   logic         s_axis_tvalid = 1'b0;
   logic [W-1:0] s_axis_tdata = '0;
   logic         s_axis_tuser = 1'b0;
   logic         s_axis_tlast = 1'b0;
   logic         s_axis_tready;
   logic         m_axis_tvalid;
   logic [W-1:0] m_axis_tdata;
   logic         m_axis_tuser;
   logic         m_axis_tlast;
   logic         m_axis_tready = 1'b1;
   logic         status_err;

   axis_bayer_subsampler #(.C_PIXEL_WIDTH(W), .C_MAX_WIDTH(CMAX)) dut (
      .clk(clk), .reset(reset),
      .cfg_mode(cfg_mode), .cfg_col_odd(cfg_col_odd), .cfg_row_odd(cfg_row_odd),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
      .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
      .s_axis_tready(s_axis_tready),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
      .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
      .m_axis_tready(m_axis_tready),
      .status_err(status_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] d;
      logic         u;
      logic         l;
   } beat_t;

   beat_t q[$];
   int    tests = 0;
   int    fails = 0;
   int    gap_pct = 0;
   int    rdy_mode = 0;
   bit    scramble = 0;

   // reference model state: frame coordinates and previous-row pair sums
   int md_mode, md_codd, md_rodd, md_col, md_row, md_p0;
   bit md_pend, md_err;
   int md_hs[HALF];

   function automatic void model_reset();
      md_mode = 0; md_codd = 0; md_rodd = 0;
      md_col = 0; md_row = 0; md_p0 = 0;
      md_pend = 0; md_err = 0;
      q.delete();
   endfunction

   function automatic void model_beat(int d, bit u, bit l);
      bit    emit = 0;
      int    o = 0;
      int    h;
      beat_t b;
      if (u) begin
         md_mode = (cfg_mode == 2'd3) ? 0 : int'(cfg_mode);
         md_codd = int'(cfg_col_odd);
         md_rodd = int'(cfg_row_odd);
         md_col = 0; md_row = 0; md_pend = 1;
      end
      case (md_mode)
         0: begin emit = 1; o = d; end
         1: if (md_col % 2 == 1 && md_row % 2 == md_rodd) begin
               emit = 1; o = (md_codd != 0) ? d : md_p0;
            end
         default: if (md_col % 2 == 1) begin
               h = md_p0 + d;
               if (md_row % 2 == 0) md_hs[(md_col / 2) % HALF] = h;
               else begin emit = 1; o = (md_hs[(md_col / 2) % HALF] + h + 2) / 4; end
            end
      endcase
      if (md_col % 2 == 0) md_p0 = d;
      if (l && md_col % 2 == 0 && md_mode != 0) md_err = 1;
      if (md_mode == 2 && md_col >= CMAX) md_err = 1;
      if (emit) begin
         b.d = o[W-1:0]; b.u = md_pend; b.l = l;
         q.push_back(b);
         md_pend = 0;
      end
      if (l) begin md_col = 0; md_row++; end
      else md_col++;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   // drive one beat; entered and left at a falling edge
   task automatic send(input int d, input bit u, input bit l);
      int waitc = 0;
      while (int'($urandom_range(99)) < gap_pct) begin
         s_axis_tvalid = 1'b0;
         @(negedge clk);
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = W'(d);
      s_axis_tuser  = u;
      s_axis_tlast  = l;
      if (!u && scramble) begin
         cfg_mode    = 2'($urandom_range(3));
         cfg_col_odd = 1'($urandom_range(1));
         cfg_row_odd = 1'($urandom_range(1));
      end
      forever begin
         #4;
         if (s_axis_tready) begin
            model_beat(d, u, l);
            @(negedge clk);
            break;
         end
         waitc++;
         if (waitc > 200) begin
            check("s_tready_timeout", 0, 1);
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      s_axis_tvalid = 1'b0;
   endtask

   // kind: 0 ramp from start, 1 all ones, 2 random, 3 10*(c+1+2r)
   task automatic frame(input int mode, input bit co, input bit ro,
                        input int w, input int h, input int kind, input int start);
      int d;
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            case (kind)
               0:       d = start + r * w + c;
               1:       d = (1 << W) - 1;
               2:       d = int'($urandom_range((1 << W) - 1));
               default: d = 10 * (c + 1 + 2 * r);
            endcase
            if (r == 0 && c == 0) begin
               cfg_mode = 2'(mode); cfg_col_odd = co; cfg_row_odd = ro;
            end
            send(d, r == 0 && c == 0, c == w - 1);
         end
      end
   endtask

   task automatic drain();
      int n = 0;
      s_axis_tvalid = 1'b0;
      while ((q.size() != 0 || m_axis_tvalid) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain_queue_empty", q.size(), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      s_axis_tvalid = 1'b0;
      repeat (3) @(negedge clk);
      model_reset();
      reset = 1'b0;
      #4;
      check("reset_m_tvalid", int'(m_axis_tvalid), 0);
      check("reset_m_tdata", int'(m_axis_tdata), 0);
      check("reset_m_tuser", int'(m_axis_tuser), 0);
      check("reset_m_tlast", int'(m_axis_tlast), 0);
      check("reset_status_err", int'(status_err), 0);
      @(negedge clk);
   endtask

   // output-ready pattern generator
   initial begin
      forever begin
         @(negedge clk);
         case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = 1'($urandom_range(1));
         endcase
      end
   end

   // monitor: pops expected beats on each handshake, checks hold under stall
   initial begin
      beat_t e;
      beat_t hb;
      beat_t got;
      bit    held = 0;
      forever begin
         @(negedge clk);
         #4;
         if (reset) begin
            held = 0;
         end else begin
            got = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
            if (held) begin
               tests++;
               if (!m_axis_tvalid || got != hb) begin
                  fails++;
                  $display("FAIL stall_hold: got v=%0b d=%0d u=%0b l=%0b, required v=1 d=%0d u=%0b l=%0b",
                           m_axis_tvalid, got.d, got.u, got.l, hb.d, hb.u, hb.l);
               end
            end
            if (m_axis_tvalid && m_axis_tready) begin
               tests++;
               if (q.size() == 0) begin
                  fails++;
                  $display("FAIL unexpected_output: got d=%0d u=%0b l=%0b, required no output",
                           got.d, got.u, got.l);
               end else begin
                  e = q.pop_front();
                  if (got != e) begin
                     fails++;
                     $display("FAIL output_beat: got d=%0d u=%0b l=%0b, required d=%0d u=%0b l=%0b",
                              got.d, got.u, got.l, e.d, e.u, e.l);
                  end
               end
            end
            held = m_axis_tvalid && !m_axis_tready;
            hb   = got;
         end
      end
   end

   initial begin
      model_reset();
      do_reset();

      // directed frames, no stalls
      rdy_mode = 0; gap_pct = 0; scramble = 0;
      frame(0, 0, 0, 4, 2, 0, 1);
      drain();
      frame(1, 1, 0, 4, 4, 0, 0);
      drain();
      frame(2, 0, 0, 4, 2, 3, 0);
      drain();
      frame(2, 0, 0, 4, 4, 1, 0);
      drain();
      check("no_err_after_directed", int'(status_err), 0);

      // random frames under back-pressure, with mid-frame cfg noise
      scramble = 1; gap_pct = 30;
      for (int i = 0; i < 40; i++) begin
         rdy_mode = (i % 2 == 0) ? 1 : 2;
         frame(int'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)),
               2 * int'($urandom_range(1, 6)), int'($urandom_range(1, 5)), 2, 0);
      end
      drain();
      check("no_err_after_random", int'(status_err), 0);

      // odd-width line in mode 1, then SOF mid-line switching to bypass
      scramble = 0; gap_pct = 0; rdy_mode = 0;
      cfg_mode = 2'd1; cfg_col_odd = 1'b0; cfg_row_odd = 1'b0;
      send(1, 1, 0); send(2, 0, 0); send(3, 0, 0); send(4, 0, 0); send(5, 0, 1);
      send(6, 0, 0); send(7, 0, 0);
      cfg_mode = 2'd0;
      send(8, 1, 0); send(9, 0, 1);
      drain();
      check("odd_width_err", int'(status_err), 1);
      do_reset();

      // line longer than the buffer in mode 2: index wraps, error flagged
      rdy_mode = 1; gap_pct = 20;
      frame(2, 0, 0, 20, 2, 2, 0);
      drain();
      check("long_line_err", int'(status_err), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish, required finish");
      $fatal(1, "timeout");
   end

endmodule
